// File: rtl/mmio_timer_bank_if.sv
// Shared memory-mapped bus port for mmio_timer_bank: byte address, write data,
// write strobe and combinational read data.
interface mmio_timer_bank_if #(
  parameter int DBITS = 32
);
  // No handshake: a write is taken on any posedge where wren is high. Read data
  // follows abus in the same cycle, with no wait states.
  logic [DBITS-1:0] abus;
  logic [DBITS-1:0] dbus_in;
  logic [DBITS-1:0] dbus_out;
  logic             wren;

  modport master (output abus, output dbus_in, output wren, input dbus_out);
  modport slave  (input abus, input dbus_in, input wren, output dbus_out);
endinterface

// File: rtl/mmio_timer_bank.sv
// Bank of NUM_CH memory-mapped up-counters sharing one prescaler and a W1C status word.
// Optional interrupt output when MMIO_TIMER_BANK_IRQ_EN is defined.
module mmio_timer_bank #(
  parameter int               DBITS     = 32,
  parameter int               NUM_CH    = 4,
  parameter logic [DBITS-1:0] BASE_ADDR = 32'hF0000100,
  parameter int               PRESCALE  = 50000
) (
  input  logic               clk,
  input  logic               rst_n,
  mmio_timer_bank_if.slave   bus
`ifdef MMIO_TIMER_BANK_IRQ_EN
  ,
  output logic               irq
`endif
);

  localparam int               PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]    PRE_MAX = PW'(PRESCALE - 1);
  localparam logic [DBITS-1:0] ONE     = DBITS'(1);

  logic [PW-1:0]    pre_cnt;
  logic             tick;

  logic [DBITS-1:0] cnt [NUM_CH];
  logic [DBITS-1:0] lim [NUM_CH];
  logic [NUM_CH-1:0] en, ar, rdy, ovr, ie;

  logic [DBITS-1:0] off;
  logic             above;
  logic             chan_hit;
  logic             stat_hit;
  logic [2:0]       chan_sel;
  logic [1:0]       reg_sel;

  logic [NUM_CH-1:0] wr_cnt, wr_lim, wr_ctl;
  logic              wr_stat;
  logic [NUM_CH-1:0] term;
  logic [DBITS-1:0]  rdata;

  // Free-running prescaler; tick is a single-cycle pulse on the last count.
  assign tick = (pre_cnt == PRE_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pre_cnt <= '0;
    else        pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
  end

  assign off      = bus.abus - BASE_ADDR;
  assign above    = (bus.abus >= BASE_ADDR);
  assign chan_hit = above && (off < DBITS'(16 * NUM_CH));
  assign stat_hit = above && (off[DBITS-1:2] == (DBITS-2)'(4 * NUM_CH));
  assign chan_sel = off[6:4];
  assign reg_sel  = off[3:2];
  assign wr_stat  = bus.wren && stat_hit;

  always_comb begin
    wr_cnt = '0;
    wr_lim = '0;
    wr_ctl = '0;
    term   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (bus.wren && chan_hit && chan_sel == 3'(c)) begin
        wr_cnt[c] = (reg_sel == 2'd0);
        wr_lim[c] = (reg_sel == 2'd1);
        wr_ctl[c] = (reg_sel == 2'd2);
      end
      // A CPU write to CNT on a tick cycle suppresses both increment and event.
      term[c] = tick && en[c] && !wr_cnt[c] && (lim[c] != '0) && (cnt[c] == lim[c] - ONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        cnt[c] <= '0;
        lim[c] <= '0;
      end
      en  <= '0;
      ar  <= '0;
      rdy <= '0;
      ovr <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (wr_lim[c]) lim[c] <= bus.dbus_in;

        if (wr_cnt[c])              cnt[c] <= bus.dbus_in;
        else if (term[c] && ar[c])  cnt[c] <= '0;
        else if (tick && en[c] && !term[c]) cnt[c] <= cnt[c] + ONE;

        if (wr_ctl[c]) begin
          en[c] <= bus.dbus_in[0];
          ar[c] <= bus.dbus_in[1];
        end else if (term[c] && !ar[c]) begin
          en[c] <= 1'b0;
        end

        // Terminal events take priority over any same-cycle clear of the flags.
        if (term[c])
          rdy[c] <= 1'b1;
        else if ((wr_ctl[c] && !bus.dbus_in[2]) || (wr_stat && bus.dbus_in[c]))
          rdy[c] <= 1'b0;

        if (term[c] && rdy[c])
          ovr[c] <= 1'b1;
        else if (wr_ctl[c] && !bus.dbus_in[3])
          ovr[c] <= 1'b0;
      end
    end
  end

`ifdef MMIO_TIMER_BANK_IRQ_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ie  <= '0;
      irq <= 1'b0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (wr_ctl[c]) ie[c] <= bus.dbus_in[4];
      end
      irq <= |(rdy & ie);
    end
  end
`else
  assign ie = '0;
`endif

  always_comb begin
    rdata = '0;
    if (stat_hit) rdata[NUM_CH-1:0] = rdy;
    for (int c = 0; c < NUM_CH; c++) begin
      if (chan_hit && chan_sel == 3'(c)) begin
        case (reg_sel)
          2'd0:    rdata = cnt[c];
          2'd1:    rdata = lim[c];
          2'd2:    rdata[4:0] = {ie[c], ovr[c], rdy[c], ar[c], en[c]};
          default: rdata = '0;
        endcase
      end
    end
  end

  assign bus.dbus_out = rdata;

endmodule

// File: tb/tb_mmio_timer_bank.sv
// Directed bench for mmio_timer_bank with PRESCALE=4, NUM_CH=4.
// Tracks the prescaler phase locally so bus writes can be aimed at tick cycles.
module tb_mmio_timer_bank;

  localparam logic [31:0] BASE   = 32'hF0000100;
  localparam logic [31:0] A_CNT0 = BASE + 32'h00;
  localparam logic [31:0] A_LIM0 = BASE + 32'h04;
  localparam logic [31:0] A_CTL0 = BASE + 32'h08;
  localparam logic [31:0] A_CNT1 = BASE + 32'h10;
  localparam logic [31:0] A_LIM1 = BASE + 32'h14;
  localparam logic [31:0] A_CTL1 = BASE + 32'h18;
  localparam logic [31:0] A_CNT2 = BASE + 32'h20;
  localparam logic [31:0] A_CTL2 = BASE + 32'h28;
  localparam logic [31:0] A_CNT3 = BASE + 32'h30;
  localparam logic [31:0] A_LIM3 = BASE + 32'h34;
  localparam logic [31:0] A_CTL3 = BASE + 32'h38;
  localparam logic [31:0] A_STAT = BASE + 32'h40;
`ifdef MMIO_TIMER_BANK_IRQ_EN
  localparam logic [31:0] EXP_DEC_CTL = 32'h13;
`else
  localparam logic [31:0] EXP_DEC_CTL = 32'h03;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic irq;
  int   checks = 0;
  int   failures = 0;
  int   tb_pre = 0;
  logic [31:0] d;

  mmio_timer_bank_if #(.DBITS(32)) bus_if ();

  mmio_timer_bank #(
    .DBITS(32), .NUM_CH(4), .BASE_ADDR(32'hF0000100), .PRESCALE(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus_if.slave)
`ifdef MMIO_TIMER_BANK_IRQ_EN
    ,
    .irq(irq)
`endif
  );

`ifndef MMIO_TIMER_BANK_IRQ_EN
  assign irq = 1'b0;
`endif

  always #5 clk = ~clk;

  // Reference prescaler phase: a tick falls in the cycle where tb_pre == 3.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_pre <= 0;
    else        tb_pre <= (tb_pre == 3) ? 0 : tb_pre + 1;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic wr(input logic [31:0] a, input logic [31:0] v);
    bus_if.abus = a; bus_if.dbus_in = v; bus_if.wren = 1'b1;
    @(negedge clk);
    bus_if.wren = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    bus_if.abus = a; bus_if.wren = 1'b0;
    #1;
    v = bus_if.dbus_out;
  endtask

  task automatic wait_tick_cycle();
    int n = 0;
    while (tb_pre != 3 && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (tb_pre != 3) begin
      failures++;
      $display("FAIL tick_sync phase=%0d required=3", tb_pre);
    end
  endtask

  task automatic pass_tick();
    wait_tick_cycle();
    @(negedge clk);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    bus_if.wren = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rd(A_CNT0, d); checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL rst_cnt0 got=%h exp=0", d); end
    rd(A_STAT, d); checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL rst_stat got=%h exp=0", d); end
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL rst_irq got=%b exp=0", irq); end
    @(negedge clk); rst_n = 1'b1;
    wr(A_CTL0, 32'h1);
    pass_tick();
    rd(A_CNT0, d); checks++;
    if (d !== 32'd1) begin failures++; $display("FAIL cnt0_first got=%h exp=1", d); end
    repeat (3) @(negedge clk);
    rd(A_CNT0, d); checks++;
    if (d !== 32'd1) begin failures++; $display("FAIL cnt0_hold3 got=%h exp=1", d); end
    @(negedge clk);
    rd(A_CNT0, d); checks++;
    if (d !== 32'd2) begin failures++; $display("FAIL cnt0_4clk got=%h exp=2", d); end
    // Asynchronous reset in the middle of the low clock phase.
    @(negedge clk); #2; rst_n = 1'b0;
    rd(A_CNT0, d); checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL async_rst_cnt0 got=%h exp=0", d); end
    rd(A_CTL0, d); checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL async_rst_ctl0 got=%h exp=0", d); end
    @(negedge clk); rst_n = 1'b1;
    wr(A_CTL0, 32'h1);
    pass_tick();
    rd(A_CNT0, d); checks++;
    if (d !== 32'd1) begin failures++; $display("FAIL resume_cnt0 got=%h exp=1", d); end
  endtask

  task automatic test_free_run_wrap();
    reset_dut();
    wr(A_CNT0, 32'hFFFF_FFFF);
    wr(A_CTL0, 32'h1);
    pass_tick();
    rd(A_CNT0, d); checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL wrap_cnt0 got=%h exp=0", d); end
    rd(A_CTL0, d); checks++;
    if (d !== 32'h1) begin failures++; $display("FAIL wrap_ctl0 got=%h exp=1", d); end
  endtask

  task automatic test_auto_reload();
    reset_dut();
    wr(A_LIM0, 32'd3);
    wr(A_CTL0, 32'h3);
    pass_tick();
    rd(A_CNT0, d); checks++;
    if (d !== 32'd1) begin failures++; $display("FAIL ar_cnt_t1 got=%h exp=1", d); end
    pass_tick(); pass_tick();
    rd(A_CNT0, d); checks++;
    if (d !== 32'd0) begin failures++; $display("FAIL ar_cnt_wrap got=%h exp=0", d); end
    rd(A_CTL0, d); checks++;
    if (d !== 32'h7) begin failures++; $display("FAIL ar_ctl_rdy got=%h exp=7", d); end
    rd(A_STAT, d); checks++;
    if (d !== 32'h1) begin failures++; $display("FAIL ar_stat got=%h exp=1", d); end
    repeat (3) pass_tick();
    rd(A_CTL0, d); checks++;
    if (d !== 32'hF) begin failures++; $display("FAIL ar_ctl_ovr got=%h exp=f", d); end
    wr(A_STAT, 32'h1);
    rd(A_CTL0, d); checks++;
    if (d !== 32'hB) begin failures++; $display("FAIL w1c_ctl got=%h exp=b", d); end
    wr(A_CTL0, 32'h3);
    rd(A_CTL0, d); checks++;
    if (d !== 32'h3) begin failures++; $display("FAIL ctl_clr got=%h exp=3", d); end
    pass_tick(); pass_tick();
    rd(A_CNT0, d); checks++;
    if (d !== 32'd2) begin failures++; $display("FAIL ar_cnt_pre got=%h exp=2", d); end
    // W1C lands on the terminal-event cycle: the event keeps RDY set.
    wait_tick_cycle();
    wr(A_STAT, 32'h1);
    rd(A_CNT0, d); checks++;
    if (d !== 32'd0) begin failures++; $display("FAIL coll_w1c_cnt got=%h exp=0", d); end
    rd(A_CTL0, d); checks++;
    if (d !== 32'h7) begin failures++; $display("FAIL coll_w1c_ctl got=%h exp=7", d); end
  endtask

  task automatic test_one_shot();
    reset_dut();
    wr(A_LIM1, 32'd5);
    wr(A_CTL1, 32'h1);
    repeat (4) pass_tick();
    rd(A_CNT1, d); checks++;
    if (d !== 32'd4) begin failures++; $display("FAIL os_cnt4 got=%h exp=4", d); end
    rd(A_CTL1, d); checks++;
    if (d !== 32'h1) begin failures++; $display("FAIL os_ctl_pre got=%h exp=1", d); end
    pass_tick();
    rd(A_CTL1, d); checks++;
    if (d !== 32'h4) begin failures++; $display("FAIL os_ctl_done got=%h exp=4", d); end
    rd(A_STAT, d); checks++;
    if (d !== 32'h2) begin failures++; $display("FAIL os_stat got=%h exp=2", d); end
    repeat (3) pass_tick();
    rd(A_CNT1, d); checks++;
    if (d !== 32'd4) begin failures++; $display("FAIL os_cnt_held got=%h exp=4", d); end
    rd(A_CTL1, d); checks++;
    if (d !== 32'h4) begin failures++; $display("FAIL os_ctl_held got=%h exp=4", d); end
  endtask

  task automatic test_collision();
    reset_dut();
    wr(A_CTL2, 32'h1);
    pass_tick(); pass_tick();
    wait_tick_cycle();
    wr(A_CNT2, 32'h10);
    rd(A_CNT2, d); checks++;
    if (d !== 32'h10) begin failures++; $display("FAIL coll_cnt_wr got=%h exp=10", d); end
    pass_tick();
    rd(A_CNT2, d); checks++;
    if (d !== 32'h11) begin failures++; $display("FAIL coll_cnt_next got=%h exp=11", d); end
    wr(A_LIM3, 32'd3);
    wr(A_CTL3, 32'h3);
    pass_tick(); pass_tick();
    wait_tick_cycle();
    wr(A_LIM3, 32'd10);
    rd(A_CNT3, d); checks++;
    if (d !== 32'd0) begin failures++; $display("FAIL coll_lim_cnt got=%h exp=0", d); end
    rd(A_CTL3, d); checks++;
    if (d !== 32'h7) begin failures++; $display("FAIL coll_lim_ctl got=%h exp=7", d); end
    rd(A_LIM3, d); checks++;
    if (d !== 32'd10) begin failures++; $display("FAIL coll_lim_val got=%h exp=a", d); end
  endtask

  task automatic test_decode();
    reset_dut();
    wr(A_LIM0, 32'h1234);
    wr(32'hF00000FC, 32'hFFFF_FFFF);
    rd(32'hF000014C, d); checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL dec_14c got=%h exp=0", d); end
    rd(32'hF00000FC, d); checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL dec_0fc got=%h exp=0", d); end
    rd(32'hF000010C, d); checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL dec_10c got=%h exp=0", d); end
    rd(A_CNT0, d); checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL dec_ignored got=%h exp=0", d); end
    wr(32'hF0000108, 32'hFF);
    rd(A_CTL0, d); checks++;
    if (d !== EXP_DEC_CTL) begin failures++; $display("FAIL dec_ctl0 got=%h exp=%h", d, EXP_DEC_CTL); end
    rd(A_LIM0, d); checks++;
    if (d !== 32'h1234) begin failures++; $display("FAIL dec_lim0 got=%h exp=1234", d); end
  endtask

`ifdef MMIO_TIMER_BANK_IRQ_EN
  task automatic test_irq();
    reset_dut();
    wr(A_LIM3, 32'd2);
    wr(A_CTL3, 32'h13);
    pass_tick();
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL irq_idle got=%b exp=0", irq); end
    wait_tick_cycle();
    @(posedge clk); #1;
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL irq_same_cycle got=%b exp=0", irq); end
    rd(A_STAT, d); checks++;
    if (d !== 32'h8) begin failures++; $display("FAIL irq_stat got=%h exp=8", d); end
    @(posedge clk); #1;
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL irq_set got=%b exp=1", irq); end
    @(negedge clk);
    bus_if.abus = A_STAT; bus_if.dbus_in = 32'h8; bus_if.wren = 1'b1;
    @(posedge clk); #1;
    bus_if.wren = 1'b0;
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL irq_clr_lag got=%b exp=1", irq); end
    @(posedge clk); #1;
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL irq_clr got=%b exp=0", irq); end
  endtask
`endif

  initial begin
    bus_if.abus = '0; bus_if.dbus_in = '0; bus_if.wren = 1'b0;
    test_reset();
    test_free_run_wrap();
    test_auto_reload();
    test_one_shot();
    test_collision();
    test_decode();
`ifdef MMIO_TIMER_BANK_IRQ_EN
    test_irq();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
